// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types and constants for the two-road intersection
//               controller. Holds the phase encoding and lamp codes.
// Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

  // Phase codes are visible on the phase output; 6 and 7 are illegal.
  typedef enum logic [2:0] {
    MAJ_G = 3'd0,
    MAJ_Y = 3'd1,
    CLR1  = 3'd2,
    MIN_G = 3'd3,
    MIN_Y = 3'd4,
    CLR2  = 3'd5
  } phase_t;

  // Lamp encoding {R,Y,G}, one-hot.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : Saturating up-counter measuring time spent in the current
//               phase. Synchronous clear restarts it at zero.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous reset, active low
//               clr   - synchronous clear (state change)
//               cnt   - cycles elapsed in the phase, saturates at all-ones
// Revision    : 1.0  initial release
// ============================================================================
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : phase_timer
`default_nettype wire

// File: rtl/traffic_controller.sv
`default_nettype none
// ============================================================================
// Module      : traffic_controller
// Description : Two-road intersection controller with yellow and all-red
//               clearance, internal phase timer, latched pedestrian request
//               and car-actuated, capped minor-road green. Outputs are
//               decoded from the state register only.
// Ports       : clk        - clock, rising edge
//               reset      - asynchronous reset, active low
//               car        - minor-road vehicle sensor (level)
//               ped_req    - pedestrian button (pulse or level)
//               major_lamp - major road {R,Y,G}
//               minor_lamp - minor road {R,Y,G}
//               walk       - pedestrian walk, high only in minor green
//               phase      - current phase code
// Revision    : 1.0  initial release
// ============================================================================
module traffic_controller
  import traffic_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int MAJ_GREEN_MIN = 8,
  parameter int YELLOW_T      = 3,
  parameter int ALLRED_T      = 1,
  parameter int MIN_GREEN_MIN = 4,
  parameter int MIN_GREEN_MAX = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car,
  input  logic       ped_req,
  output logic [2:0] major_lamp,
  output logic [2:0] minor_lamp,
  output logic       walk,
  output logic [2:0] phase
);

  // Last count value of each phase (a phase of DUR cycles ends when the
  // counter reads DUR-1 at the edge).
  localparam logic [CNT_W-1:0] c_maj_last    = CNT_W'(MAJ_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] c_yel_last    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] c_clr_last    = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] c_min_lo_last = CNT_W'(MIN_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] c_min_hi_last = CNT_W'(MIN_GREEN_MAX - 1);

  phase_t           state_q;
  phase_t           state_d;
  logic             ped_pend_q;
  logic             ped_pend_d;
  logic [CNT_W-1:0] cnt;
  logic             state_chg;
  logic             req;

  assign req       = car | ped_pend_q;
  assign state_chg = (state_d != state_q);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_chg),
    .cnt   (cnt)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAJ_G: if ((cnt >= c_maj_last) && req) state_d = MAJ_Y;
      MAJ_Y: if (cnt == c_yel_last)          state_d = CLR1;
      CLR1:  if (cnt == c_clr_last)          state_d = MIN_G;
      MIN_G: if (((cnt >= c_min_lo_last) && !car) || (cnt == c_min_hi_last))
               state_d = MIN_Y;
      MIN_Y: if (cnt == c_yel_last)          state_d = CLR2;
      CLR2:  if (cnt == c_clr_last)          state_d = MAJ_G;
      default:                               state_d = MAJ_G;
    endcase
  end

  // Pedestrian latch. Entry into minor green serves every pending request,
  // so the clear takes priority over a press seen on that same edge.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if ((state_d == MIN_G) && (state_q != MIN_G)) begin
      ped_pend_d = 1'b0;
    end else if (ped_req && (state_q != MIN_G)) begin
      ped_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= MAJ_G;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  // Moore output decode
  always_comb begin
    major_lamp = LAMP_G;
    minor_lamp = LAMP_R;
    walk       = 1'b0;
    case (state_q)
      MAJ_G: begin major_lamp = LAMP_G; minor_lamp = LAMP_R; end
      MAJ_Y: begin major_lamp = LAMP_Y; minor_lamp = LAMP_R; end
      CLR1,
      CLR2:  begin major_lamp = LAMP_R; minor_lamp = LAMP_R; end
      MIN_G: begin major_lamp = LAMP_R; minor_lamp = LAMP_G; walk = 1'b1; end
      MIN_Y: begin major_lamp = LAMP_R; minor_lamp = LAMP_Y; end
      default: begin major_lamp = LAMP_G; minor_lamp = LAMP_R; end
    endcase
  end

  assign phase = state_q;

endmodule : traffic_controller
`default_nettype wire

// File: doc/traffic_controller.md
# traffic_controller

Parametrised two-road intersection controller, next generation of the single-bit major/minor light FSM. It adds:
- yellow and all-red clearance phases;
- an internal phase timer in place of the external `timed` input;
- a latched pedestrian request;
- a car-actuated, capped extension of minor green.

It sits between the road sensors and the lamp drivers and is the only sequential owner of lamp state.

## Interface
- `CNT_W`, 8: phase-timer width. Every duration below must be ≤ 2^CNT_W.
- `MAJ_GREEN_MIN`, 8: minimum major-green cycles before a request is served (≥1).
- `YELLOW_T`, 3: yellow cycles, both roads (≥1).
- `ALLRED_T`, 1: all-red clearance cycles (≥1).
- `MIN_GREEN_MIN`, 4: minimum minor-green cycles (≥1).
- `MIN_GREEN_MAX`, 10: maximum minor-green cycles (≥ `MIN_GREEN_MIN`).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `car` in 1: minor-road vehicle sensor, level, synchronous to `clk`.
- `ped_req` in 1: pedestrian button, synchronous pulse or level.
- `major_lamp` out 3: {R,Y,G}, one-hot.
- `minor_lamp` out 3: {R,Y,G}, one-hot.
- `walk` out 1: pedestrian walk signal.
- `phase` out 3: current state code.

## Operation
- States and codes:
  - MAJ_G = 0, MAJ_Y = 1, CLR1 = 2, MIN_G = 3, MIN_Y = 4, CLR2 = 5.
  - Codes 6 and 7 are illegal; they go to MAJ_G on the next edge.
- Lamps per state:
  - MAJ_G: major G, minor R.
  - MAJ_Y: major Y, minor R.
  - CLR1 and CLR2: both R.
  - MIN_G: major R, minor G, `walk` = 1.
  - MIN_Y: major R, minor Y.
- `walk` = 1 only in MIN_G.
- Phase timer `cnt`:
  - Cleared to 0 on every state change.
  - Otherwise increments, saturating at 2^CNT_W−1.
- `ped_pend` register:
  - Set at any edge where `ped_req` = 1 and the state is not MIN_G.
  - Cleared on entry to MIN_G.
  - `ped_req` during MIN_G is ignored.
- `req` = `car` | `ped_pend`.
- Transitions (evaluated at the edge):
  - MAJ_G → MAJ_Y when `cnt` ≥ MAJ_GREEN_MIN−1 and `req`. Otherwise stay; major green is unbounded with no request.
  - MAJ_Y → CLR1 when `cnt` = YELLOW_T−1.
  - CLR1 → MIN_G when `cnt` = ALLRED_T−1.
  - MIN_G → MIN_Y when either:
    - `cnt` ≥ MIN_GREEN_MIN−1 and `car` = 0, or
    - `cnt` = MIN_GREEN_MAX−1, regardless of `car`.
  - MIN_Y → CLR2 when `cnt` = YELLOW_T−1.
  - CLR2 → MAJ_G when `cnt` = ALLRED_T−1.
- Simultaneous `car` and `ped_req` are served in one minor cycle.
- A request arriving in MAJ_Y, CLR1, MIN_Y or CLR2:
  - `ped_pend` holds it, and it is served after the next MAJ_GREEN_MIN.
  - `car` is not latched. A car must still be present in MAJ_G to be served.

## Timing
- Reset asserted (async):
  - `phase` = 0, `cnt` = 0, `ped_pend` = 0.
  - `major_lamp` = 3'b001, `minor_lamp` = 3'b100, `walk` = 0.
  - Takes effect immediately, mid-phase included, with no yellow or clearance.
- All outputs are decoded from the state register only (Moore). They change only at the clock edge that changes state.
- A timed state entered at edge E is left at edge E+DUR, so it lasts exactly DUR cycles.
- MAJ_G with `req` continuously high lasts exactly MAJ_GREEN_MIN cycles.
- Request-to-minor-green latency, with the request seen at an edge after MAJ_GREEN_MIN has elapsed: 1 + YELLOW_T + ALLRED_T edges.
- MIN_G duration:
  - `car` = 0 throughout: MIN_GREEN_MIN cycles.
  - `car` = 1 throughout: MIN_GREEN_MAX cycles.
  - `car` dropping at cycle k: max(MIN_GREEN_MIN, k+1) cycles.

## Structure
- `traffic_pkg` holds:
  - the state enum `phase_t` (3 bits, codes above);
  - lamp constants `LAMP_R` = 3'b100, `LAMP_Y` = 3'b010, `LAMP_G` = 3'b001.
- Sub-module `phase_timer`:
  - parameter `CNT_W`; inputs `clk`, `reset`, `clr`; output `cnt`;
  - saturating up-counter.
- The top level holds the FSM, `ped_pend` and the output decode.

## Test plan
All scenarios use default parameters.
- **Reset:** assert `reset` = 0 mid-MIN_G (`phase` = 3) → same cycle: `phase` = 0, `major_lamp` = 001, `minor_lamp` = 100, `walk` = 0. After release with no requests, stays in `phase` 0 for 50 cycles.
- **Early car:** `car` = 1 from cycle 0 after reset and held → MAJ_G 8, MAJ_Y 3, CLR1 1, MIN_G 10 (capped), MIN_Y 3, CLR2 1 cycles. Back in MAJ_G at cycle 26 (MAJ_G entry at edge 26 from reset release).
- **Car drop:** `car` pulses 1 cycle at cycle 20 → MAJ_Y at edge 21. MIN_G lasts exactly 4 cycles, `walk` = 1 only for those 4.
- **Pedestrian:**
  - `ped_req` 1-cycle pulse at cycle 2, `car` = 0 → `ped_pend` holds. MAJ_Y entered at edge 8. MIN_G lasts 4 cycles, with `walk` = 1.
  - Second pulse during MIN_G → ignored; next MAJ_G is unbounded.
- **Late request:** `ped_req` pulse during MIN_Y → after CLR2, MAJ_G lasts exactly 8 cycles, then a new minor cycle.
- **Corner cases:**
  - `car` toggling every cycle during MIN_G → MIN_G ends at the first edge at or after cycle 4 where `car` = 0.
  - Force `phase` = 7 → `phase` = 0 next edge.
